// File: rtl/tdm_demux.sv
// Receive-side bit-level TDM demultiplexer: serial slots in, double-buffered parallel channels out.
// Optional even-parity slot at index CHANNELS is compiled in with `define TDM_PARITY_EN.
module tdm_demux #(
    parameter int CHANNELS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                din_i,
    input  logic                din_valid_i,
    input  logic                frame_sync_i,
    output logic [CHANNELS-1:0] dout_o,
    output logic                frame_done_o,
    output logic                locked_o,
    output logic                sync_err_o,
    output logic                parity_err_o
);

`ifdef TDM_PARITY_EN
    localparam int FRAME_LEN = CHANNELS + 1;
`else
    localparam int FRAME_LEN = CHANNELS;
`endif
    localparam int                SLOT_W    = $clog2(FRAME_LEN);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_LEN - 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);

    // Handshake: din_i and frame_sync_i are consumed on every rising edge where din_valid_i=1;
    // there is no back-pressure, the link never stalls the sender.
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e                state_q,      state_d;
    logic [SLOT_W-1:0]     slot_q,       slot_d;
    logic [FRAME_LEN-1:0]  shadow_q,     shadow_d;
    logic [CHANNELS-1:0]   dout_q,       dout_d;
    logic                  frame_done_q, frame_done_d;
    logic                  sync_err_q,   sync_err_d;
`ifdef TDM_PARITY_EN
    logic                  parity_err_q, parity_err_d;
`endif

    logic [FRAME_LEN-1:0]  frame_full;
    logic                  frame_ok;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            slot_q       <= '0;
            shadow_q     <= '0;
            dout_q       <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
`ifdef TDM_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            shadow_q     <= shadow_d;
            dout_q       <= dout_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
`ifdef TDM_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Shadow contents as they would be with the current bit written into its slot.
    always_comb begin
        frame_full         = shadow_q;
        frame_full[slot_q] = din_i;
`ifdef TDM_PARITY_EN
        frame_ok = ~(^frame_full);
`else
        frame_ok = 1'b1;
`endif
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        shadow_d     = shadow_q;
        dout_d       = dout_q;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
`ifdef TDM_PARITY_EN
        parity_err_d = 1'b0;
`endif
        if (din_valid_i) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync_i) begin
                        shadow_d[0] = din_i;
                        slot_d      = SLOT_ONE;
                        state_d     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync_i && (slot_q != '0)) begin
                        // Early sync restarts the frame here; the partial frame is dropped.
                        sync_err_d  = 1'b1;
                        shadow_d[0] = din_i;
                        slot_d      = SLOT_ONE;
                    end else if (!frame_sync_i && (slot_q == '0)) begin
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                    end else begin
                        shadow_d = frame_full;
                        if (slot_q == LAST_SLOT) begin
                            slot_d = '0;
                            if (frame_ok) begin
                                dout_d       = frame_full[CHANNELS-1:0];
                                frame_done_d = 1'b1;
                            end
`ifdef TDM_PARITY_EN
                            else begin
                                parity_err_d = 1'b1;
                            end
`endif
                        end else begin
                            slot_d = slot_q + SLOT_ONE;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Output logic
    always_comb begin
        dout_o       = dout_q;
        frame_done_o = frame_done_q;
        sync_err_o   = sync_err_q;
        locked_o     = (state_q == LOCKED);
`ifdef TDM_PARITY_EN
        parity_err_o = parity_err_q;
`else
        parity_err_o = 1'b0;
`endif
    end

endmodule
